dff_bist: RTL

Synthesizable built-in self-test sequencer that drives the DUT side of a single D flip-flop (dff module: d, reset, clk, q) and checks its response.
- Steps through a walk of {d, reset} vectors and holds each for a programmable number of cycles.
- Samples the flop's q and compares it against the expected value.
- Reports pass/fail, an error count and the first failing vector index.
- Sits beside a dff instance on the same clock. It replaces a simulation-only stimulus loop with hardware usable on FPGA.

---
 rtl/dff_bist_pkg.sv | 20 ++
 rtl/dff_bist_vecgen.sv | 28 ++
 rtl/dff_bist.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/dff_bist_pkg.sv
// Shared definitions for the dff_bist self-test sequencer.
// Contents: FSM state encoding, the bit positions of the {reset, d} fields
// inside a vector index, and the expected-q function of a sync-reset flop.
package dff_bist_pkg;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Vector index bit positions: index bit 0 drives d, bit 1 drives reset
  localparam int unsigned D_BIT   = 0;
  localparam int unsigned RST_BIT = 1;

  // Flop with active-high sync reset: q follows d unless reset is applied
  function automatic logic exp_val(input logic d, input logic rst);
    return rst ? 1'b0 : d;
  endfunction

endpackage

// File: rtl/dff_bist_vecgen.sv
// Vector generator for dff_bist: maps a vector index to the {d, reset}
// stimulus and the q value a healthy flop must show for it.
// Pattern repeats modulo 4, so only the two low index bits matter.
// Ports:
//   idx_i  vector index
//   d_o    d value to apply
//   rst_o  reset value to apply
//   exp_o  expected q once the vector has been captured
module dff_bist_vecgen
  import dff_bist_pkg::*;
#(
  parameter int unsigned IDX_W = 2
) (
  input  logic [IDX_W-1:0] idx_i,
  output logic             d_o,
  output logic             rst_o,
  output logic             exp_o
);

  // Width-normalised index; extends narrow indices, truncates wide ones
  logic [1:0] sel;

  assign sel   = 2'(idx_i);
  assign d_o   = sel[D_BIT];
  assign rst_o = sel[RST_BIT];
  assign exp_o = exp_val(d_o, rst_o);

endmodule

// File: rtl/dff_bist.sv
// Built-in self-test sequencer for a single D flip-flop (d, reset, clk, q).
// Walks NUM_VECTORS {d, reset} vectors, holds each for HOLD_CYCLES clocks,
// checks q on the last edge of each hold and reports pass/fail, an error
// count and the first failing vector index.
// Ports:
//   clk         clock shared with the flop under test
//   reset       synchronous active-low reset of this block
//   start       one-cycle pulse, starts a run from idle or done
//   dut_q       q of the flop under test
//   dut_d       d to the flop under test
//   dut_reset   active-high sync reset to the flop under test
//   busy        run in progress
//   done        run finished, results valid until next start or reset
//   pass        with done: no mismatches in the run
//   err_count   mismatch count, saturating
//   fail_valid  at least one mismatch this run
//   fail_idx    index of the first mismatching vector
module dff_bist
  import dff_bist_pkg::*;
#(
  parameter  int unsigned NUM_VECTORS = 4,
  parameter  int unsigned HOLD_CYCLES = 2,
  localparam int unsigned IDX_W       = (NUM_VECTORS > 1) ? $clog2(NUM_VECTORS) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             dut_q,
  output logic             dut_d,
  output logic             dut_reset,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [IDX_W:0]   err_count,
  output logic             fail_valid,
  output logic [IDX_W-1:0] fail_idx
);

  localparam int unsigned ERR_W  = IDX_W + 1;
  localparam int unsigned HCNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_VECTORS - 1);
  localparam logic [HCNT_W-1:0] HOLD_LAST = HCNT_W'(HOLD_CYCLES - 1);

  logic [1:0]        state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [HCNT_W-1:0] hold_q, hold_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic              fv_q, fv_d;
  logic [IDX_W-1:0]  fi_q, fi_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic              dut_d_q, dut_d_d;
  logic              dut_rst_q, dut_rst_d;
  logic              exp_q, exp_d;

  logic vg_d, vg_rst, vg_exp;
  logic run_next;

  // Stimulus for the vector that will be applied after this edge
  dff_bist_vecgen #(
    .IDX_W (IDX_W)
  ) u_vecgen (
    .idx_i (idx_d),
    .d_o   (vg_d),
    .rst_o (vg_rst),
    .exp_o (vg_exp)
  );

  // Outside a run the flop is parked in reset with d low
  assign run_next  = (state_d == ST_RUN);
  assign dut_d_d   = run_next ? vg_d   : 1'b0;
  assign dut_rst_d = run_next ? vg_rst : 1'b1;
  assign exp_d     = vg_exp;

  // Next-state and result logic
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    hold_d  = hold_q;
    err_d   = err_q;
    fv_d    = fv_q;
    fi_d    = fi_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;

    case (state_q)
      ST_RUN: begin
        hold_d = hold_q + HCNT_W'(1);
        // Last edge of the hold: q has had one full cycle since capture
        if (hold_q == HOLD_LAST) begin
          if (dut_q != exp_q) begin
            if (err_q != '1) begin
              err_d = err_q + ERR_W'(1);
            end
            if (!fv_q) begin
              fv_d = 1'b1;
              fi_d = idx_q;
            end
          end
          if (idx_q != LAST_IDX) begin
            idx_d  = idx_q + IDX_W'(1);
            hold_d = '0;
          end else begin
            state_d = ST_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_d == '0);
          end
        end
      end
      default: begin
        // Idle or done: start launches a fresh run, busy ignores start
        if (start) begin
          state_d = ST_RUN;
          idx_d   = '0;
          hold_d  = '0;
          err_d   = '0;
          fv_d    = 1'b0;
          fi_d    = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          pass_d  = 1'b0;
        end
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      hold_q    <= '0;
      err_q     <= '0;
      fv_q      <= 1'b0;
      fi_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      dut_d_q   <= 1'b0;
      dut_rst_q <= 1'b1;
      exp_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      hold_q    <= hold_d;
      err_q     <= err_d;
      fv_q      <= fv_d;
      fi_q      <= fi_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      dut_d_q   <= dut_d_d;
      dut_rst_q <= dut_rst_d;
      exp_q     <= exp_d;
    end
  end

  assign dut_d      = dut_d_q;
  assign dut_reset  = dut_rst_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_count  = err_q;
  assign fail_valid = fv_q;
  assign fail_idx   = fi_q;

endmodule
